// File: rtl/shift_reg_universal.sv
// Universal shift register: hold/load/shift/rotate/arithmetic-shift with registered serial out.
// Burst engine runs a latched operation count times autonomously, signalling busy/done.
module shift_reg_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] par_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [WIDTH-1:0] P,
  output logic             sout_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ROL  = 3'd4;
  localparam logic [2:0] M_ROR  = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [2:0]       w_op;
  logic             w_start_ok;
  logic [CNT_W-1:0] w_cnt_sat;
  logic [WIDTH-1:0] w_p_nxt;
  logic             w_sout_nxt;

  // Only the shift/rotate modes can be bursted; LOAD/HOLD/reserved fall back to single-step.
  assign w_start_ok = start_i && (mode_i >= M_SHL) && (mode_i <= M_ASR);
  assign w_cnt_sat  = (count_i > LP_CNT_MAX) ? LP_CNT_MAX : count_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= M_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok && (w_cnt_sat != '0)) w_state_nxt = S_BURST;
      S_BURST: if (r_cnt == LP_CNT_ONE) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_op       = M_HOLD;
    w_cnt_nxt  = r_cnt;
    w_mode_nxt = r_mode;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          // Accept edge performs no operation; a zero-length burst completes immediately.
          if (w_cnt_sat == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt  = w_cnt_sat;
            w_mode_nxt = mode_i;
          end
        end else begin
          w_op = mode_i;
        end
      end
      S_BURST: begin
        w_op      = r_mode;
        w_cnt_nxt = r_cnt - LP_CNT_ONE;
        if (r_cnt == LP_CNT_ONE) w_done_nxt = 1'b1;
      end
      default: w_op = M_HOLD;
    endcase
  end

  always_comb begin
    w_p_nxt    = P;
    w_sout_nxt = sout_o;
    case (w_op)
      M_LOAD: w_p_nxt = par_i;
      M_SHL: begin
        w_p_nxt    = {P[WIDTH-2:0], sin_i};
        w_sout_nxt = P[WIDTH-1];
      end
      M_SHR: begin
        w_p_nxt    = {sin_i, P[WIDTH-1:1]};
        w_sout_nxt = P[0];
      end
      M_ROL: begin
        w_p_nxt    = {P[WIDTH-2:0], P[WIDTH-1]};
        w_sout_nxt = P[WIDTH-1];
      end
      M_ROR: begin
        w_p_nxt    = {P[0], P[WIDTH-1:1]};
        w_sout_nxt = P[0];
      end
      M_ASR: begin
        w_p_nxt    = {P[WIDTH-1], P[WIDTH-1:1]};
        w_sout_nxt = P[0];
      end
      default: begin
        w_p_nxt    = P;
        w_sout_nxt = sout_o;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      P      <= '0;
      sout_o <= 1'b0;
    end else begin
      P      <= w_p_nxt;
      sout_o <= w_sout_nxt;
    end
  end

  assign busy_o = (r_state == S_BURST);
  assign done_o = r_done;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed bench for shift_reg_universal: table of single-step vectors plus burst/reset sequences,
// on an 8-bit and a 16-bit instance.
module tb_shift_reg_universal;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ROL  = 3'd4;
  localparam logic [2:0] M_ROR  = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;
  localparam logic [2:0] M_RSV  = 3'd7;

  logic        clk;
  logic        rst;
  logic [2:0]  mode8, mode16;
  logic        sin8, sin16;
  logic [7:0]  par8;
  logic [15:0] par16;
  logic        start8, start16;
  logic [3:0]  cnt8;
  logic [4:0]  cnt16;
  logic [7:0]  p8;
  logic [15:0] p16;
  logic        sout8, sout16, busy8, busy16, done8, done16;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] mode;
    logic       sin;
    logic       start;
    logic [3:0] cnt;
    logic [7:0] par;
    logic [7:0] exp_p;
    logic       exp_sout;
  } vec_t;

  vec_t vecs[20];

  shift_reg_universal #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .mode_i(mode8), .sin_i(sin8), .par_i(par8),
    .start_i(start8), .count_i(cnt8), .P(p8), .sout_o(sout8),
    .busy_o(busy8), .done_o(done8)
  );

  shift_reg_universal #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .mode_i(mode16), .sin_i(sin16), .par_i(par16),
    .start_i(start16), .count_i(cnt16), .P(p16), .sout_o(sout16),
    .busy_o(busy16), .done_o(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load8(input logic [7:0] v);
    mode8 = M_LOAD; par8 = v; start8 = 1'b0;
    tick();
    mode8 = M_HOLD;
  endtask

  task automatic load16(input logic [15:0] v);
    mode16 = M_LOAD; par16 = v; start16 = 1'b0;
    tick();
    mode16 = M_HOLD;
  endtask

  task automatic observe(input bit sel, input int n, output int nb, output int nd);
    logic b, d;
    nb = 0;
    nd = 0;
    for (int i = 0; i < n; i++) begin
      b = sel ? busy16 : busy8;
      d = sel ? done16 : done8;
      if (b) nb++;
      if (d) nd++;
      chk("busy_done_exclusive", {31'b0, b & d}, 32'd0);
      tick();
    end
  endtask

  initial begin
    int nb, nd;

    vecs[0]  = '{M_LOAD, 1'b0, 1'b0, 4'd0, 8'hA5, 8'hA5, 1'b0};
    vecs[1]  = '{M_SHL,  1'b1, 1'b0, 4'd0, 8'h00, 8'h4B, 1'b1};
    vecs[2]  = '{M_SHR,  1'b0, 1'b0, 4'd0, 8'h00, 8'h25, 1'b1};
    vecs[3]  = '{M_HOLD, 1'b0, 1'b0, 4'd0, 8'hFF, 8'h25, 1'b1};
    vecs[4]  = '{M_HOLD, 1'b1, 1'b0, 4'd0, 8'hFF, 8'h25, 1'b1};
    vecs[5]  = '{M_HOLD, 1'b0, 1'b0, 4'd0, 8'hFF, 8'h25, 1'b1};
    vecs[6]  = '{M_RSV,  1'b1, 1'b0, 4'd0, 8'hFF, 8'h25, 1'b1};
    vecs[7]  = '{M_LOAD, 1'b0, 1'b0, 4'd0, 8'h90, 8'h90, 1'b1};
    vecs[8]  = '{M_ASR,  1'b0, 1'b0, 4'd0, 8'h00, 8'hC8, 1'b0};
    vecs[9]  = '{M_ASR,  1'b1, 1'b0, 4'd0, 8'h00, 8'hE4, 1'b0};
    vecs[10] = '{M_ROL,  1'b0, 1'b0, 4'd0, 8'h00, 8'hC9, 1'b1};
    vecs[11] = '{M_ROR,  1'b0, 1'b0, 4'd0, 8'h00, 8'hE4, 1'b1};
    vecs[12] = '{M_ROR,  1'b1, 1'b0, 4'd0, 8'h00, 8'h72, 1'b0};
    vecs[13] = '{M_SHL,  1'b0, 1'b0, 4'd0, 8'h00, 8'hE4, 1'b0};
    vecs[14] = '{M_SHR,  1'b1, 1'b0, 4'd0, 8'h00, 8'hF2, 1'b0};
    vecs[15] = '{M_LOAD, 1'b0, 1'b0, 4'd0, 8'h01, 8'h01, 1'b0};
    vecs[16] = '{M_SHR,  1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1};
    vecs[17] = '{M_LOAD, 1'b0, 1'b1, 4'd3, 8'h3C, 8'h3C, 1'b1};
    vecs[18] = '{M_HOLD, 1'b0, 1'b1, 4'd2, 8'hFF, 8'h3C, 1'b1};
    vecs[19] = '{M_RSV,  1'b1, 1'b1, 4'd2, 8'hFF, 8'h3C, 1'b1};

    // Reset with LOAD pending must still clear everything.
    rst = 1'b1;
    mode8 = M_LOAD;  par8 = 8'h77;     sin8 = 1'b0;  start8 = 1'b0;  cnt8 = '0;
    mode16 = M_LOAD; par16 = 16'h7777; sin16 = 1'b0; start16 = 1'b0; cnt16 = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_p", 32'(p8), 32'h00);
    chk("rst_sout", 32'(sout8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_p16", 32'(p16), 32'h0000);
    mode8 = M_HOLD;
    mode16 = M_HOLD;
    rst = 1'b0;
    tick();
    chk("rst_release_p", 32'(p8), 32'h00);

    for (int i = 0; i < 20; i++) begin
      mode8 = vecs[i].mode; sin8 = vecs[i].sin; start8 = vecs[i].start;
      cnt8 = vecs[i].cnt; par8 = vecs[i].par;
      tick();
      chk($sformatf("vec%0d_p", i), 32'(p8), 32'(vecs[i].exp_p));
      chk($sformatf("vec%0d_sout", i), 32'(sout8), 32'(vecs[i].exp_sout));
      chk($sformatf("vec%0d_busy", i), 32'(busy8), 32'd0);
      chk($sformatf("vec%0d_done", i), 32'(done8), 32'd0);
    end
    mode8 = M_HOLD; start8 = 1'b0; sin8 = 1'b0;

    // Burst ROL x3 from 81.
    load8(8'h81);
    mode8 = M_ROL; start8 = 1'b1; cnt8 = 4'd3;
    tick();
    start8 = 1'b0; mode8 = M_HOLD;
    chk("rol_accept_noop_p", 32'(p8), 32'h81);
    observe(1'b0, 6, nb, nd);
    chk("rol_busy_cycles", 32'(nb), 32'd3);
    chk("rol_done_pulses", 32'(nd), 32'd1);
    chk("rol_p", 32'(p8), 32'h0C);
    chk("rol_sout", 32'(sout8), 32'd0);

    // count 15 saturates to 8: full rotation.
    load8(8'h81);
    mode8 = M_ROL; start8 = 1'b1; cnt8 = 4'd15;
    tick();
    start8 = 1'b0; mode8 = M_HOLD;
    observe(1'b0, 11, nb, nd);
    chk("sat8_busy_cycles", 32'(nb), 32'd8);
    chk("sat8_done_pulses", 32'(nd), 32'd1);
    chk("sat8_p", 32'(p8), 32'h81);
    chk("sat8_sout", 32'(sout8), 32'd1);

    // Deserialise 8 bits; mode/par/start disturbed mid-burst.
    load8(8'h00);
    mode8 = M_SHR; start8 = 1'b1; cnt8 = 4'd8;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("deser_busy%0d", i), 32'(busy8), 32'd1);
      sin8 = (i % 2 == 0);
      mode8 = (i == 3) ? M_LOAD : M_SHR;
      par8 = 8'hFF;
      start8 = (i == 2);
      cnt8 = 4'd1;
      tick();
    end
    mode8 = M_HOLD; start8 = 1'b0; sin8 = 1'b0;
    chk("deser_p", 32'(p8), 32'h55);
    chk("deser_done", 32'(done8), 32'd1);
    chk("deser_busy_end", 32'(busy8), 32'd0);
    tick();
    chk("deser_done_clear", 32'(done8), 32'd0);
    chk("deser_p_hold", 32'(p8), 32'h55);

    // Reset mid-burst abandons it silently.
    load8(8'hFF);
    mode8 = M_SHL; sin8 = 1'b0; start8 = 1'b1; cnt8 = 4'd6;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    chk("midrst_pre_p", 32'(p8), 32'hFC);
    chk("midrst_pre_busy", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_p", 32'(p8), 32'h00);
    chk("midrst_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    mode8 = M_HOLD;
    rst = 1'b0;
    observe(1'b0, 8, nb, nd);
    chk("midrst_busy_after", 32'(nb), 32'd0);
    chk("midrst_done_after", 32'(nd), 32'd0);
    chk("midrst_p_after", 32'(p8), 32'h00);

    // Zero-length burst, then a new burst accepted in the done cycle.
    load8(8'h3C);
    mode8 = M_SHL; start8 = 1'b1; cnt8 = 4'd0;
    tick();
    chk("cnt0_done", 32'(done8), 32'd1);
    chk("cnt0_busy", 32'(busy8), 32'd0);
    chk("cnt0_p", 32'(p8), 32'h3C);
    mode8 = M_ROL; start8 = 1'b1; cnt8 = 4'd1;
    tick();
    start8 = 1'b0; mode8 = M_HOLD;
    chk("restart_busy", 32'(busy8), 32'd1);
    chk("restart_done", 32'(done8), 32'd0);
    chk("restart_p0", 32'(p8), 32'h3C);
    tick();
    chk("restart_done2", 32'(done8), 32'd1);
    chk("restart_p", 32'(p8), 32'h78);
    tick();
    chk("restart_done_clear", 32'(done8), 32'd0);

    // 16-bit instance: ROR 15 == ROL 1, then saturated full rotation.
    load16(16'h8001);
    mode16 = M_ROR; start16 = 1'b1; cnt16 = 5'd15;
    tick();
    start16 = 1'b0; mode16 = M_HOLD;
    observe(1'b1, 18, nb, nd);
    chk("w16_ror_busy", 32'(nb), 32'd15);
    chk("w16_ror_done", 32'(nd), 32'd1);
    chk("w16_ror_p", 32'(p16), 32'h0003);
    mode16 = M_ROR; start16 = 1'b1; cnt16 = 5'd31;
    tick();
    start16 = 1'b0; mode16 = M_HOLD;
    observe(1'b1, 19, nb, nd);
    chk("w16_sat_busy", 32'(nb), 32'd16);
    chk("w16_sat_done", 32'(nd), 32'd1);
    chk("w16_sat_p", 32'(p16), 32'h0003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
